// File: rtl/time_display_pkg.sv
// Shared constants for the MM.SS time display: active-low segment patterns
// ({g,f,e,d,c,b,a}) and the digit-slot indices used by the scanner.
package time_display_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit slot order: S-ones first, M-tens last (end of frame)
  localparam logic [1:0] IDX_S_ONES = 2'd0;
  localparam logic [1:0] IDX_S_TENS = 2'd1;
  localparam logic [1:0] IDX_M_ONES = 2'd2;
  localparam logic [1:0] IDX_M_TENS = 2'd3;

endpackage

// File: rtl/time_display_scanner_bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Non-decimal nibbles (10-15) show a dash so bad timer data is visible.
import time_display_pkg::*;

module bcd_to_seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Lookup of the segment pattern for one nibble
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/time_display_scanner.sv
// Multiplexed 4-digit MM.SS display driver. A prescaler steps a digit index
// once per SCAN_DIV clocks; the time value is captured only at frame
// boundaries so a frame never mixes old and new digits. The MM.SS separator
// flashes for half a second after each seconds change and stays on while
// frozen.
import time_display_pkg::*;

module time_display_scanner #(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] time_value,
  input  logic        freeze,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        dp_n
);

  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HALF = CLK_HZ / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HALF_MAX  = HW'(HALF - 1);

  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [15:0]   snap_reg;
  logic [3:0]    sones_prev_reg;
  logic [HW-1:0] half_reg;
  logic          scan_tick;
  logic          blink_on;
  logic          sones_changed;
  logic          m_tens_blank;
  logic [3:0]    digit_nib;
  logic [6:0]    dec_seg;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;

  assign scan_tick = (presc_reg == PRESC_MAX);

  // Prescaler, digit index and frame snapshot (captured on the last slot's tick)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      idx_reg   <= IDX_S_ONES;
      snap_reg  <= '0;
    end else begin
      presc_reg <= scan_tick ? '0 : presc_reg + 1'b1;
      if (scan_tick) begin
        idx_reg <= idx_reg + 2'd1;
        if ((idx_reg == IDX_M_TENS) && !freeze)
          snap_reg <= time_value;
      end
    end
  end

  assign sones_changed = (snap_reg[3:0] != sones_prev_reg);

  // Half-second separator timer: reload on a seconds change, else count down to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sones_prev_reg <= '0;
      half_reg       <= '0;
    end else begin
      sones_prev_reg <= snap_reg[3:0];
      if (sones_changed)
        half_reg <= HALF_MAX;
      else if (half_reg != '0)
        half_reg <= half_reg - 1'b1;
    end
  end

  assign blink_on = (half_reg != '0) || freeze;

  // Select the nibble for the current digit slot
  always_comb begin
    digit_nib = snap_reg[3:0];
    case (idx_reg)
      IDX_S_ONES: digit_nib = snap_reg[3:0];
      IDX_S_TENS: digit_nib = snap_reg[7:4];
      IDX_M_ONES: digit_nib = snap_reg[11:8];
      IDX_M_TENS: digit_nib = snap_reg[15:12];
      default:    digit_nib = snap_reg[3:0];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd   (digit_nib),
    .seg_n (dec_seg)
  );

  // Leading zero of the minutes is suppressed entirely
  assign m_tens_blank = (idx_reg == IDX_M_TENS) && (snap_reg[15:12] == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = ~((idx_reg == 2'(gi)) && !m_tens_blank);
    end
  endgenerate

  assign seg_next = m_tens_blank ? SEG_BLANK : dec_seg;
  assign dp_next  = ~((idx_reg == IDX_M_ONES) && blink_on);

  // Registered pin drivers; dark while in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= 4'b1111;
      seg_n <= SEG_BLANK;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
      dp_n  <= dp_next;
    end
  end

endmodule

// File: tb/tb_time_display_scanner.sv
// Self-checking bench for time_display_scanner with a fast scan (SCAN_DIV=4,
// CLK_HZ=16). The reference model works from edge counts since reset release:
// slot = (edges / SCAN_DIV) mod 4, frames latch the input, and the separator
// window is expressed as a range of edges after the last seconds change.
module tb_time_display_scanner;

  localparam int SD   = 4;
  localparam int HZ   = 16;
  localparam int HALF = HZ / 2;

  logic        clk;
  logic        reset;
  logic [15:0] time_value;
  logic        freeze;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        dp_n;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_e;     // edges since reset release
  logic [15:0] m_snap;  // digits currently shown
  int          m_chg;   // edge at which the shown S-ones last changed

  time_display_scanner #(.CLK_HZ(HZ), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .reset      (reset),
    .time_value (time_value),
    .freeze     (freeze),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .dp_n       (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    return t[v];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e    = 0;
    m_snap = 16'h0000;
    m_chg  = -1000;
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"},  {12'h0, an_n},  16'h000F);
    chk({tag, "_seg"}, {9'h0, seg_n},  16'h007F);
    chk({tag, "_dp"},  {15'h0, dp_n},  16'h0001);
  endtask

  // One clock: predict the registered outputs from the pre-edge model, then advance it
  task automatic step();
    logic [15:0] tv;
    logic        fz;
    int          idx;
    int          since;
    logic        blink;
    logic [3:0]  nib;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        ed;
    @(posedge clk);
    tv    = time_value;
    fz    = freeze;
    idx   = (m_e / SD) % 4;
    since = m_e - m_chg - 1;
    blink = fz || (since >= 1 && since <= HALF - 1);
    nib   = m_snap[idx*4 +: 4];
    if (idx == 3 && m_snap[15:12] == 4'd0) begin
      ea = 4'b1111;
      es = 7'h7F;
    end else begin
      ea = ~(4'b0001 << idx);
      es = seg_of(nib);
    end
    ed = !(idx == 2 && blink);
    if ((m_e % SD) == SD - 1 && idx == 3 && !fz) begin
      if (tv[3:0] != m_snap[3:0]) m_chg = m_e;
      m_snap = tv;
    end
    m_e++;
    #1;
    chk("an_n",  {12'h0, an_n},  {12'h0, ea});
    chk("seg_n", {9'h0, seg_n},  {9'h0, es});
    chk("dp_n",  {15'h0, dp_n},  {15'h0, ed});
    $display("edge=%0d tv=%h frz=%0d an_n=%b seg_n=%b dp_n=%b", m_e - 1, tv, fz, an_n, seg_n, dp_n);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset      = 1'b0;
    time_value = 16'h0000;
    freeze     = 1'b0;
    #2 reset = 1'b1;
    #1 check_dark("reset_async");
    @(posedge clk); #1 check_dark("reset_held");
    @(negedge clk) reset = 1'b0;
    model_reset();

    // Full value, all four digits lit
    time_value = 16'h1259;
    run(40);

    // Leading minute zero blanked
    time_value = 16'h0305;
    run(36);

    // Mid-frame seconds change, visible only at the next frame boundary
    time_value = 16'h0010;
    run(34);
    time_value = 16'h0011;
    run(40);

    // Freeze holds the digits and keeps the separator on
    time_value = 16'h0142;
    run(20);
    freeze = 1'b1;
    run(10);
    time_value = 16'h0150;
    run(36);
    freeze = 1'b0;
    run(40);

    // Non-decimal digit shows a dash
    time_value = 16'h00A0;
    run(36);

    // Asynchronous reset in the middle of a slot
    run(5);
    #1 reset = 1'b1;
    #1 check_dark("reset_midslot");
    @(posedge clk); #1 check_dark("reset_midslot_held");
    @(negedge clk) reset = 1'b0;
    model_reset();
    time_value = 16'h0742;
    run(24);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0)
        time_value = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 29) == 0)
        freeze = ~freeze;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
